// File: rtl/bulk_in_axis_arbiter_if.sv
// AXIS bundle between NUM_CHAN bulk IN producers, the arbiter and the endpoint FIFO write port.
// Latency: none, wires only.
// Backpressure: carries per-producer tready and the single downstream m_axis_tready.
interface bulk_in_axis_arbiter_if #(
  parameter int NUM_CHAN = 4
);
  logic [NUM_CHAN-1:0]   s_axis_tvalid;
  logic [NUM_CHAN-1:0]   s_axis_tready;
  logic [NUM_CHAN-1:0]   s_axis_tlast;
  logic [8*NUM_CHAN-1:0] s_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;
  logic [7:0]            m_axis_tdata;

  // master: the arbiter, which owns the merged stream and the producer readies
  modport master (
    input  s_axis_tvalid, s_axis_tlast, s_axis_tdata, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata
  );

  // slave: the surroundings (producers plus endpoint FIFO)
  modport slave (
    output s_axis_tvalid, s_axis_tlast, s_axis_tdata, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata
  );
endinterface

// File: rtl/bulk_in_axis_arbiter.sv
// Packet-level round-robin merge of up to four AXIS producers into the bulk IN endpoint stream.
// Latency: 1 IDLE decision cycle + optional header beat per burst, then combinational pass-through.
// Backpressure: m_axis_tready is forwarded only to the granted producer; all others see tready=0.
module bulk_in_axis_arbiter #(
  parameter int NUM_CHAN = 4,
  parameter int MAX_LEN  = 512,
  parameter int HEADER   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  bulk_in_axis_arbiter_if.master axis,
  output logic [NUM_CHAN-1:0]   grant_o,
  output logic                  busy_o
);
  localparam int CW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, HEAD = 2'd1, DATA = 2'd2} state_t;

  state_t              state_q, state_d;
  // ptr_q doubles as the current channel: it is loaded with the winner and only moves in IDLE
  logic [1:0]          ptr_q, ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_CHAN-1:0] grant_q, grant_d;

  logic                sel_vld;
  logic                sel_last;
  logic [7:0]          sel_dat;
  logic                scan_hit;
  logic [1:0]          scan_chan;
  int                  scan_best;
  int                  scan_dist;
  logic                beat_last;

  // mux the granted producer's stream using the registered one-hot grant
  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_dat  = 8'h00;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (grant_q[i]) begin
        sel_vld  = axis.s_axis_tvalid[i];
        sel_last = axis.s_axis_tlast[i];
        sel_dat  = axis.s_axis_tdata[8*i +: 8];
      end
    end
  end

  // rotating scan: the valid channel nearest after ptr_q wins, ptr_q itself ranks last
  always_comb begin
    scan_best = NUM_CHAN;
    scan_dist = 0;
    scan_chan = ptr_q;
    for (int i = 0; i < NUM_CHAN; i++) begin
      scan_dist = (i + 2 * NUM_CHAN - int'(ptr_q) - 1) % NUM_CHAN;
      if (axis.s_axis_tvalid[i] && (scan_dist < scan_best)) begin
        scan_best = scan_dist;
        scan_chan = 2'(i);
      end
    end
    scan_hit = (scan_best < NUM_CHAN);
  end

  // next-state and stream outputs for IDLE / HEAD / DATA
  always_comb begin
    state_d            = state_q;
    ptr_d              = ptr_q;
    cnt_d              = cnt_q;
    grant_d            = grant_q;
    beat_last          = 1'b0;
    axis.m_axis_tvalid = 1'b0;
    axis.m_axis_tlast  = 1'b0;
    axis.m_axis_tdata  = 8'h00;
    axis.s_axis_tready = '0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (scan_hit) begin
          ptr_d = scan_chan;
          for (int i = 0; i < NUM_CHAN; i++) begin
            grant_d[i] = (scan_chan == 2'(i));
          end
          state_d = (HEADER != 0) ? HEAD : DATA;
        end
      end
      HEAD: begin
        // header goes out regardless of the producer's current tvalid
        axis.m_axis_tvalid = 1'b1;
        axis.m_axis_tdata  = {4'hC, 2'b00, ptr_q};
        if (axis.m_axis_tready) begin
          cnt_d   = cnt_q + CW'(1);
          state_d = DATA;
        end
      end
      DATA: begin
        // burst also closes at MAX_LEN beats; the producer resumes with a fresh header later
        beat_last          = sel_last | (cnt_q == CW'(MAX_LEN - 1));
        axis.m_axis_tvalid = sel_vld;
        axis.m_axis_tdata  = sel_dat;
        axis.m_axis_tlast  = beat_last;
        axis.s_axis_tready = grant_q & {NUM_CHAN{axis.m_axis_tready}};
        if (sel_vld && axis.m_axis_tready) begin
          cnt_d = cnt_q + CW'(1);
          if (beat_last) begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // state registers; reset leaves channel 0 first in line
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'(NUM_CHAN - 1);
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);
endmodule

// File: tb/tb_bulk_in_axis_arbiter.sv
// Bench for bulk_in_axis_arbiter: 4-channel/MAX_LEN=8/header instance and 2-channel headerless instance.
// Expected streams come from a packet-level scheduling model over preloaded producer queues.
// Downstream readiness is driven constant or random; inputs change at negedge, outputs sampled 1ns later.
`timescale 1ns/1ps
module tb_bulk_in_axis_arbiter;
  localparam int NA = 4;
  localparam int LA = 8;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  bulk_in_axis_arbiter_if #(.NUM_CHAN(NA)) bus_a ();
  bulk_in_axis_arbiter_if #(.NUM_CHAN(2))  bus_c ();
  logic [NA-1:0] grant_a;
  logic          busy_a;
  logic [1:0]    grant_c;
  logic          busy_c;

  bulk_in_axis_arbiter #(.NUM_CHAN(NA), .MAX_LEN(LA), .HEADER(1)) dut_a (
    .clk(clk), .rst(rst), .axis(bus_a), .grant_o(grant_a), .busy_o(busy_a)
  );
  bulk_in_axis_arbiter #(.NUM_CHAN(2), .MAX_LEN(16), .HEADER(0)) dut_c (
    .clk(clk), .rst(rst), .axis(bus_c), .grant_o(grant_c), .busy_o(busy_c)
  );

  int checks = 0;
  int failures = 0;

  // producer queues: each entry {tlast, tdata}
  logic [8:0] src [NA][64];
  int         src_len [NA];
  int         src_head [NA];
  logic [8:0] exp_q [$];
  logic [8:0] obs_q [$];
  int         obs_cyc [$];
  int         mirror_err;
  bit         timed_out;

  task automatic clear_src();
    for (int i = 0; i < NA; i++) begin
      src_len[i]  = 0;
      src_head[i] = 0;
    end
  endtask

  task automatic load_pkt(input int c, input int len);
    for (int k = 0; k < len; k++) begin
      src[c][src_len[c]] = {(k == len - 1), 8'($urandom)};
      src_len[c]++;
    end
  endtask

  task automatic drive_src_a();
    logic [NA-1:0]   v;
    logic [NA-1:0]   l;
    logic [8*NA-1:0] d;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < NA; i++) begin
      if (src_head[i] < src_len[i]) begin
        v[i]       = 1'b1;
        l[i]       = src[i][src_head[i]][8];
        d[8*i +: 8] = src[i][src_head[i]][7:0];
      end
    end
    bus_a.s_axis_tvalid = v;
    bus_a.s_axis_tlast  = l;
    bus_a.s_axis_tdata  = d;
  endtask

  function automatic bit drained();
    bit r;
    r = 1'b1;
    for (int i = 0; i < NA; i++) if (src_head[i] < src_len[i]) r = 1'b0;
    return r;
  endfunction

  // scheduling model: next non-empty queue after the last served one, header, then
  // bytes until producer tlast or until the burst reaches LA beats
  task automatic build_expected();
    int h [NA];
    int ptr, c, cc, n;
    logic [8:0] b;
    bit last;
    exp_q.delete();
    for (int i = 0; i < NA; i++) h[i] = src_head[i];
    ptr = NA - 1;
    while (1) begin
      c = -1;
      for (int k = 1; k <= NA; k++) begin
        cc = (ptr + k) % NA;
        if (c < 0 && h[cc] < src_len[cc]) c = cc;
      end
      if (c < 0) break;
      ptr = c;
      exp_q.push_back({1'b0, 8'hC0 | 8'(c)});
      n = 1;
      do begin
        b = src[c][h[c]];
        h[c]++;
        n++;
        last = b[8] || (n == LA);
        exp_q.push_back({last, b[7:0]});
      end while (!last);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_src();
    drive_src_a();
    bus_a.m_axis_tready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // runs dut_a until all queues drain and it returns to idle, recording output beats
  task automatic run_traffic(input int max_cyc, input bit rand_rdy);
    int cyc;
    bit done;
    logic [NA-1:0] pop;
    cyc = 0; done = 1'b0;
    obs_q.delete(); obs_cyc.delete();
    mirror_err = 0; timed_out = 1'b0;
    while (!done) begin
      @(negedge clk);
      drive_src_a();
      bus_a.m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (bus_a.m_axis_tvalid && bus_a.m_axis_tready) begin
        obs_q.push_back({bus_a.m_axis_tlast, bus_a.m_axis_tdata});
        obs_cyc.push_back(cyc);
      end
      if ((bus_a.s_axis_tready & ~grant_a) != '0) mirror_err++;
      if ((bus_a.s_axis_tready != '0) && !bus_a.m_axis_tready) mirror_err++;
      if (busy_a != (grant_a != '0)) mirror_err++;
      pop = bus_a.s_axis_tvalid & bus_a.s_axis_tready;
      if (drained() && !busy_a && !bus_a.m_axis_tvalid) done = 1'b1;
      else if (cyc >= max_cyc) begin
        timed_out = 1'b1;
        done = 1'b1;
      end
      @(posedge clk);
      for (int i = 0; i < NA; i++) if (pop[i]) src_head[i]++;
      cyc++;
    end
    @(negedge clk);
    bus_a.m_axis_tready = 1'b0;
    drive_src_a();
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_src();
    for (int i = 0; i < NA; i++) load_pkt(i, 3);
    drive_src_a();
    build_expected();
    rst = 1'b1;
    bus_a.m_axis_tready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if ({bus_a.m_axis_tvalid, bus_a.m_axis_tlast, bus_a.m_axis_tdata} !== 10'd0) begin
        failures++;
        $display("FAIL reset_m_axis got=%b want=0", {bus_a.m_axis_tvalid, bus_a.m_axis_tlast, bus_a.m_axis_tdata});
      end
      checks++;
      if (bus_a.s_axis_tready !== 4'b0000) begin
        failures++;
        $display("FAIL reset_s_tready got=%b want=0000", bus_a.s_axis_tready);
      end
      checks++;
      if ({grant_a, busy_a} !== 5'd0) begin
        failures++;
        $display("FAIL reset_grant_busy got=%b want=00000", {grant_a, busy_a});
      end
    end
    @(negedge clk);
    bus_a.m_axis_tready = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (grant_a !== 4'b0001 || busy_a !== 1'b1 || bus_a.m_axis_tvalid !== 1'b1 || bus_a.m_axis_tdata !== 8'hC0) begin
      failures++;
      $display("FAIL reset_first_grant got=grant %b data %h want=grant 0001 data c0", grant_a, bus_a.m_axis_tdata);
    end
    run_traffic(400, 1'b0);
    checks++;
    if (timed_out || obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL reset_stream_len got=%0d want=%0d timeout=%0d", obs_q.size(), exp_q.size(), timed_out);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL reset_beat[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    load_pkt(0, 4); load_pkt(2, 4); load_pkt(3, 4);
    drive_src_a();
    build_expected();
    run_traffic(200, 1'b0);
    checks++;
    if (timed_out || obs_q.size() != 15) begin
      failures++;
      $display("FAIL rr_stream_len got=%0d want=15 timeout=%0d", obs_q.size(), timed_out);
    end
    checks++;
    if (obs_q[0] !== 9'h0C0 || obs_q[5] !== 9'h0C2 || obs_q[10] !== 9'h0C3) begin
      failures++;
      $display("FAIL rr_headers got=%h %h %h want=0c0 0c2 0c3", obs_q[0], obs_q[5], obs_q[10]);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rr_beat[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]);
      end
    end
    for (int j = 1; j < obs_q.size(); j++) begin
      if (obs_q[j-1][8]) begin
        checks++;
        if (obs_cyc[j] - obs_cyc[j-1] != 2) begin
          failures++;
          $display("FAIL rr_idle_gap[%0d] got=%0d want=2", j, obs_cyc[j] - obs_cyc[j-1]);
        end
      end
    end
  endtask

  task automatic test_truncation();
    do_reset();
    load_pkt(1, 20);
    drive_src_a();
    build_expected();
    run_traffic(300, 1'b0);
    checks++;
    if (timed_out || obs_q.size() != 23) begin
      failures++;
      $display("FAIL trunc_stream_len got=%0d want=23 timeout=%0d", obs_q.size(), timed_out);
    end
    checks++;
    if (obs_q[0] !== 9'h0C1 || obs_q[8] !== 9'h0C1 || obs_q[16] !== 9'h0C1) begin
      failures++;
      $display("FAIL trunc_headers got=%h %h %h want=0c1 0c1 0c1", obs_q[0], obs_q[8], obs_q[16]);
    end
    checks++;
    if (obs_q[7][8] !== 1'b1 || obs_q[15][8] !== 1'b1 || obs_q[22][8] !== 1'b1 || obs_q[6][8] !== 1'b0) begin
      failures++;
      $display("FAIL trunc_tlast got=%b%b%b%b want=0111", obs_q[6][8], obs_q[7][8], obs_q[15][8], obs_q[22][8]);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL trunc_beat[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < NA; i++) begin
      load_pkt(i, $urandom_range(1, 12));
      load_pkt(i, $urandom_range(1, 12));
    end
    drive_src_a();
    build_expected();
    run_traffic(3000, 1'b1);
    checks++;
    if (timed_out || obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL bp_stream_len got=%0d want=%0d timeout=%0d", obs_q.size(), exp_q.size(), timed_out);
    end
    checks++;
    if (mirror_err != 0) begin
      failures++;
      $display("FAIL bp_tready_mirror got=%0d violations want=0", mirror_err);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL bp_beat[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int hs;
    bit fired;
    logic [NA-1:0] pop;
    do_reset();
    load_pkt(2, 6);
    drive_src_a();
    hs = 0; fired = 1'b0;
    for (int cyc = 0; cyc < 50 && !fired; cyc++) begin
      @(negedge clk);
      bus_a.m_axis_tready = 1'b1;
      drive_src_a();
      #1;
      if (bus_a.m_axis_tvalid && hs == 3) begin
        rst = 1'b1;
        fired = 1'b1;
      end else if (bus_a.m_axis_tvalid) hs++;
      pop = bus_a.s_axis_tvalid & bus_a.s_axis_tready;
      @(posedge clk);
      for (int i = 0; i < NA; i++) if (pop[i]) src_head[i]++;
    end
    #1;
    checks++;
    if (!fired || bus_a.m_axis_tvalid !== 1'b0 || grant_a !== 4'b0000 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL midrst_abort got=fired %0d vld %b grant %b busy %b want=1 0 0000 0",
               fired, bus_a.m_axis_tvalid, grant_a, busy_a);
    end
    @(negedge clk);
    bus_a.m_axis_tready = 1'b0;
    clear_src();
    load_pkt(1, 2);
    load_pkt(3, 2);
    drive_src_a();
    build_expected();
    rst = 1'b0;
    run_traffic(200, 1'b0);
    checks++;
    if (timed_out || obs_q.size() != 6 || obs_q[0] !== 9'h0C1) begin
      failures++;
      $display("FAIL midrst_restart got=len %0d first %h want=len 6 first 0c1", obs_q.size(), obs_q[0]);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL midrst_beat[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_header_off();
    int seq0, seq1, nbeat;
    logic [8:0] want;
    logic [1:0] pop;
    @(negedge clk);
    rst = 1'b1;
    bus_c.s_axis_tvalid = 2'b11;
    bus_c.s_axis_tlast  = 2'b11;
    bus_c.s_axis_tdata  = 16'h1000;
    bus_c.m_axis_tready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seq0 = 0; seq1 = 0; nbeat = 0;
    for (int it = 0; it < 21; it++) begin
      bus_c.s_axis_tdata = {8'(16 + seq1), 8'(seq0)};
      #1;
      pop = bus_c.s_axis_tvalid & bus_c.s_axis_tready;
      if (bus_c.m_axis_tvalid && bus_c.m_axis_tready) begin
        want = {1'b1, 8'(16 * (nbeat % 2) + nbeat / 2)};
        checks++;
        if ({bus_c.m_axis_tlast, bus_c.m_axis_tdata} !== want) begin
          failures++;
          $display("FAIL nohdr_beat[%0d] got=%h want=%h", nbeat, {bus_c.m_axis_tlast, bus_c.m_axis_tdata}, want);
        end
        checks++;
        if (bus_c.s_axis_tready !== 2'(1 << (nbeat % 2))) begin
          failures++;
          $display("FAIL nohdr_s_tready[%0d] got=%b want=%b", nbeat, bus_c.s_axis_tready, 2'(1 << (nbeat % 2)));
        end
        nbeat++;
      end
      @(posedge clk);
      if (pop[0]) seq0++;
      if (pop[1]) seq1++;
      @(negedge clk);
    end
    checks++;
    if (nbeat != 10) begin
      failures++;
      $display("FAIL nohdr_beat_count got=%0d want=10", nbeat);
    end
    bus_c.s_axis_tvalid = 2'b00;
    bus_c.m_axis_tready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clear_src();
    drive_src_a();
    bus_a.m_axis_tready = 1'b0;
    bus_c.s_axis_tvalid = 2'b00;
    bus_c.s_axis_tlast  = 2'b00;
    bus_c.s_axis_tdata  = 16'h0000;
    bus_c.m_axis_tready = 1'b0;
    test_reset();
    test_round_robin();
    test_truncation();
    test_backpressure();
    test_reset_mid_burst();
    test_header_off();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
